// File: rtl/proc_bus_master_pkg.sv
// Shared definitions for the processor-side AddrData bus master.
// Holds the default bus geometry and the burst state encoding used by
// proc_bus_master. No ports; imported by the top with import mcDefs::*.
package mcDefs;

  // Default AddrData width (address and data share the bus).
  localparam int BUSWIDTH        = 16;
  // Default number of data beats that follow each address phase.
  localparam int DATAPAYLOADSIZE = 4;

  // Burst sequencing states; PBM_TURN is only reached when the turnaround
  // option is compiled in.
  typedef enum logic [2:0] {
    PBM_IDLE,
    PBM_ADDR,
    PBM_LAT,
    PBM_DATA,
    PBM_DONE,
    PBM_TURN
  } pbm_state_t;

endpackage

// File: rtl/proc_bus_master_beat_ctr.sv
// pbm_beat_ctr: loadable down-counter used by the bus master both to time
// the read-latency gap and to step through the data beats.
// Ports:
//   clk      in   system clock
//   resetH   in   synchronous active-high reset, clears the count
//   load     in   load load_val this cycle (wins over en)
//   load_val in   W-bit value to load
//   en       in   decrement by one (saturates at zero)
//   cnt      out  current count
//   last     out  count has reached zero
module pbm_beat_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         resetH,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;

  // Count register: a load restarts the phase, otherwise count down and
  // park at zero so the counter never wraps.
  always_ff @(posedge clk) begin
    if (resetH) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/proc_bus_master.sv
// proc_bus_master: CPU-side master for the multiplexed AddrData bus.
// Takes one read/write request at a time over valid/ready, runs an address
// phase, an optional read-latency gap and PAYLOAD data beats, then pulses
// rsp_valid with the gathered read data. The pad itself lives above this
// block; here the bus is split into ad_out / ad_oe / ad_in.
// Optional feature macro: PBM_TURNAROUND_EN adds one undriven TURN cycle
// after every burst before the next request can be accepted.
// Ports:
//   clk, resetH           clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_rw                1 = read, 0 = write
//   req_addr              burst start address
//   req_wdata             write beats, beat k at [k*BUSWIDTH +: BUSWIDTH]
//   rsp_valid             one-cycle burst-complete pulse
//   rsp_rdata             last completed read's data, same packing
//   ad_out/ad_oe/ad_in    split tristate AddrData bus
//   addr_valid, rw        address-phase strobe and direction
module proc_bus_master
  import mcDefs::*;
#(
  parameter int BUSWIDTH = mcDefs::BUSWIDTH,
  parameter int PAYLOAD  = mcDefs::DATAPAYLOADSIZE,
  parameter int RD_LAT   = 0
) (
  input  logic                          clk,
  input  logic                          resetH,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_rw,
  input  logic [BUSWIDTH-1:0]           req_addr,
  input  logic [PAYLOAD*BUSWIDTH-1:0]   req_wdata,
  output logic                          rsp_valid,
  output logic [PAYLOAD*BUSWIDTH-1:0]   rsp_rdata,
  output logic [BUSWIDTH-1:0]           ad_out,
  output logic                          ad_oe,
  input  logic [BUSWIDTH-1:0]           ad_in,
  output logic                          addr_valid,
  output logic                          rw
);

  localparam int BEATW = $clog2(PAYLOAD) + 1;
  localparam int LATW  = $clog2(RD_LAT + 1) + 1;
  localparam int CW    = (BEATW > LATW) ? BEATW : LATW;
  localparam int DW    = PAYLOAD * BUSWIDTH;

  pbm_state_t          state_q, state_d;
  logic                rw_q, rw_d;
  logic [BUSWIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]       wbuf_q, wbuf_d;
  logic [DW-1:0]       rbuf_q, rbuf_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  logic                ctrLoad, ctrEn, ctrLast;
  logic [CW-1:0]       ctrLoadVal, ctrCnt, beatIdx;
  logic [BUSWIDTH-1:0] wbeat;

  pbm_beat_ctr #(.W(CW)) u_beat_ctr (
    .clk      (clk),
    .resetH   (resetH),
    .load     (ctrLoad),
    .load_val (ctrLoadVal),
    .en       (ctrEn),
    .cnt      (ctrCnt),
    .last     (ctrLast)
  );

  // The counter runs down during DATA, so the beat index is its complement.
  assign beatIdx = CW'(PAYLOAD - 1) - ctrCnt;

  // State register.
  always_ff @(posedge clk) begin
    if (resetH) begin
      state_q <= PBM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: address phase, optional latency gap, data beats,
  // one response cycle and, if compiled in, a turnaround cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PBM_IDLE: if (req_valid) state_d = PBM_ADDR;
      PBM_ADDR: state_d = (rw_q && (RD_LAT > 0)) ? PBM_LAT : PBM_DATA;
      PBM_LAT:  if (ctrLast) state_d = PBM_DATA;
      PBM_DATA: if (ctrLast) state_d = PBM_DONE;
      PBM_DONE: begin
`ifdef PBM_TURNAROUND_EN
        state_d = PBM_TURN;
`else
        state_d = PBM_IDLE;
`endif
      end
      default:  state_d = PBM_IDLE;
    endcase
  end

  // Counter control: ADDR preloads either the latency gap or the beat
  // count; the end of LAT reloads the beat count for DATA.
  always_comb begin
    ctrLoad    = 1'b0;
    ctrLoadVal = '0;
    ctrEn      = 1'b0;
    case (state_q)
      PBM_ADDR: begin
        ctrLoad    = 1'b1;
        ctrLoadVal = (rw_q && (RD_LAT > 0)) ? CW'(RD_LAT - 1) : CW'(PAYLOAD - 1);
      end
      PBM_LAT: begin
        if (ctrLast) begin
          ctrLoad    = 1'b1;
          ctrLoadVal = CW'(PAYLOAD - 1);
        end else begin
          ctrEn = 1'b1;
        end
      end
      PBM_DATA: ctrEn = 1'b1;
      default: ;
    endcase
  end

  // Request latching and read capture. The response copy is taken from
  // rbuf_d so the final beat sampled on the same edge is included.
  always_comb begin
    rw_d    = rw_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    if (state_q == PBM_IDLE && req_valid) begin
      rw_d   = req_rw;
      addr_d = req_addr;
      wbuf_d = req_wdata;
    end
    if (state_q == PBM_DATA && rw_q) begin
      for (int k = 0; k < PAYLOAD; k++) begin
        if (beatIdx == CW'(k)) rbuf_d[k*BUSWIDTH +: BUSWIDTH] = ad_in;
      end
      if (ctrLast) rdata_d = rbuf_d;
    end
  end

  // Datapath registers; reset also clears the buffers of an aborted burst.
  always_ff @(posedge clk) begin
    if (resetH) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
    end
  end

  // Write beat selection from the latched buffer.
  always_comb begin
    wbeat = '0;
    for (int k = 0; k < PAYLOAD; k++) begin
      if (beatIdx == CW'(k)) wbeat = wbuf_q[k*BUSWIDTH +: BUSWIDTH];
    end
  end

  // Outputs depend only on the state and latched values, never on req_*.
  always_comb begin
    req_ready  = (state_q == PBM_IDLE);
    rsp_valid  = (state_q == PBM_DONE);
    ad_oe      = 1'b0;
    ad_out     = '0;
    addr_valid = 1'b0;
    rw         = 1'b0;
    case (state_q)
      PBM_ADDR: begin
        ad_oe      = 1'b1;
        ad_out     = addr_q;
        addr_valid = 1'b1;
        rw         = rw_q;
      end
      PBM_DATA: begin
        if (!rw_q) begin
          ad_oe  = 1'b1;
          ad_out = wbeat;
        end
      end
      default: ;
    endcase
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_proc_bus_master.sv
// Testbench for proc_bus_master. Three instances cover the default
// geometry (16/4/0), a 16/4/2 read-latency build and a 32/8/1 wide build;
// a selector routes the shared stimulus to one instance at a time and
// muxes its outputs back for checking against a phase-by-phase model.
module tb_proc_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetH;
  logic         reqValid, reqRw;
  logic [31:0]  reqAddr;
  logic [255:0] reqWdata;
  logic [31:0]  adIn;
  int           sel;

  int vectors = 0;
  int miscompares = 0;

  // Configuration of each instance: bus width, payload beats, read latency.
  int cfgBw  [3] = '{16, 32, 16};
  int cfgPl  [3] = '{4, 8, 4};
  int cfgLat [3] = '{2, 1, 0};

  // Last completed read data per instance (reference model state).
  logic [255:0] lastRdata [3];

  logic         readyA, rspA, oeA, avA, rwA;
  logic [63:0]  rdataA;
  logic [15:0]  adOutA;
  logic         readyB, rspB, oeB, avB, rwB;
  logic [255:0] rdataB;
  logic [31:0]  adOutB;
  logic         readyC, rspC, oeC, avC, rwC;
  logic [63:0]  rdataC;
  logic [15:0]  adOutC;

  logic         obsReady, obsRsp, obsOe, obsAv, obsRw;
  logic [31:0]  obsAd;
  logic [255:0] obsRdata;

  proc_bus_master #(.BUSWIDTH(16), .PAYLOAD(4), .RD_LAT(2)) dutA (
    .clk(clk), .resetH(resetH), .req_valid(reqValid && (sel == 0)), .req_ready(readyA),
    .req_rw(reqRw), .req_addr(reqAddr[15:0]), .req_wdata(reqWdata[63:0]),
    .rsp_valid(rspA), .rsp_rdata(rdataA), .ad_out(adOutA), .ad_oe(oeA),
    .ad_in(adIn[15:0]), .addr_valid(avA), .rw(rwA)
  );

  proc_bus_master #(.BUSWIDTH(32), .PAYLOAD(8), .RD_LAT(1)) dutB (
    .clk(clk), .resetH(resetH), .req_valid(reqValid && (sel == 1)), .req_ready(readyB),
    .req_rw(reqRw), .req_addr(reqAddr), .req_wdata(reqWdata),
    .rsp_valid(rspB), .rsp_rdata(rdataB), .ad_out(adOutB), .ad_oe(oeB),
    .ad_in(adIn), .addr_valid(avB), .rw(rwB)
  );

  proc_bus_master dutC (
    .clk(clk), .resetH(resetH), .req_valid(reqValid && (sel == 2)), .req_ready(readyC),
    .req_rw(reqRw), .req_addr(reqAddr[15:0]), .req_wdata(reqWdata[63:0]),
    .rsp_valid(rspC), .rsp_rdata(rdataC), .ad_out(adOutC), .ad_oe(oeC),
    .ad_in(adIn[15:0]), .addr_valid(avC), .rw(rwC)
  );

  // Route the selected instance's outputs to the common observation signals.
  always_comb begin
    obsReady = readyC; obsRsp = rspC; obsOe = oeC; obsAv = avC; obsRw = rwC;
    obsAd = 32'(adOutC); obsRdata = 256'(rdataC);
    case (sel)
      0: begin
        obsReady = readyA; obsRsp = rspA; obsOe = oeA; obsAv = avA; obsRw = rwA;
        obsAd = 32'(adOutA); obsRdata = 256'(rdataA);
      end
      1: begin
        obsReady = readyB; obsRsp = rspB; obsOe = oeB; obsAv = avB; obsRw = rwB;
        obsAd = adOutB; obsRdata = rdataB;
      end
      default: ;
    endcase
  end

  // One complete burst on the selected instance, checked cycle by cycle
  // against the expected phase sequence. Starts and ends just after an edge.
  task automatic run_burst(input logic rw, input logic [31:0] addr,
                           input logic [255:0] wdata, input logic [255:0] rdin,
                           input string name);
    int bw, pl, lat, total, dataStart, beat;
    logic [31:0]  mask, expAd;
    logic [255:0] dmask, prevRd, expRd;
    logic         expOe;
    logic [36:0]  obsV, expV;
    bw  = cfgBw[sel];
    pl  = cfgPl[sel];
    lat = cfgLat[sel];
    mask  = (bw == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    dmask = (pl * bw >= 256) ? {256{1'b1}} : ((256'd1 << (pl * bw)) - 256'd1);
    prevRd = lastRdata[sel];
    expRd  = rw ? (rdin & dmask) : prevRd;
    total     = 1 + (rw ? lat : 0) + pl + 1;
    dataStart = 2 + (rw ? lat : 0);

    vectors++;
    if (obsReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s ready_before: observed %b expected 1", name, obsReady);
    end
    reqValid = 1'b1; reqRw = rw; reqAddr = addr; reqWdata = wdata; adIn = $urandom;
    @(posedge clk); #1;
    reqValid = 1'b0; reqRw = 1'($urandom); reqAddr = $urandom; reqWdata = {8{$urandom}};

    for (int t = 1; t <= total; t++) begin
      expOe = (t == 1) || (!rw && t >= dataStart && t < total);
      beat  = t - dataStart;
      if (t == 1) expAd = addr & mask;
      else if (expOe) expAd = 32'(wdata >> (beat * bw)) & mask;
      else expAd = 32'h0;
      expV = {1'b0, (t == total), expOe, (t == 1), (t == 1) ? rw : 1'b0, expAd};
      obsV = {obsReady, obsRsp, obsOe, obsAv, (t == 1) ? obsRw : 1'b0,
              expOe ? obsAd : 32'h0};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL %s bus cycle %0d: observed %h expected %h", name, t, obsV, expV);
      end
      vectors++;
      if (obsRdata !== ((t == total) ? expRd : prevRd)) begin
        miscompares++;
        $display("[TB] FAIL %s rdata cycle %0d: observed %h expected %h", name, t, obsRdata,
                 (t == total) ? expRd : prevRd);
      end
      if (rw && t >= dataStart && t < total) adIn = 32'(rdin >> (beat * bw)) & mask;
      else adIn = $urandom;
      @(posedge clk); #1;
    end

    vectors++;
    if (obsRsp !== 1'b0 || obsRdata !== expRd) begin
      miscompares++;
      $display("[TB] FAIL %s after_done: observed rsp %b rdata %h expected rsp 0 rdata %h",
               name, obsRsp, obsRdata, expRd);
    end
`ifdef PBM_TURNAROUND_EN
    vectors++;
    if (obsOe !== 1'b0 || obsReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s turn: observed oe %b ready %b expected 0 0", name, obsOe, obsReady);
    end
    @(posedge clk); #1;
`endif
    vectors++;
    if (obsReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s ready_after: observed %b expected 1", name, obsReady);
    end
    lastRdata[sel] = expRd;
  endtask

  task automatic test_reset();
    resetH = 1'b1; reqValid = 1'b0; reqRw = 1'b0; reqAddr = '0; reqWdata = '0; adIn = '0;
    sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      vectors++;
      if ({obsReady, obsRsp, obsOe, obsAv, obsRw} !== 5'b10000 || obsAd !== 32'h0 ||
          obsRdata !== 256'h0) begin
        miscompares++;
        $display("[TB] FAIL reset dut%0d: observed ctl %b ad %h rdata %h expected ctl 10000, 0, 0",
                 s, {obsReady, obsRsp, obsOe, obsAv, obsRw}, obsAd, obsRdata);
      end
    end
    for (int s = 0; s < 3; s++) lastRdata[s] = '0;
    resetH = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_defaults();
    sel = 2; #1;
    run_burst(1'b0, 32'h1234, 256'h4444_3333_2222_1111, '0, "write_defaults");
  endtask

  task automatic test_read_lat2();
    sel = 0; #1;
    run_burst(1'b1, 32'h0040, {8{$urandom}}, 256'h00A3_00A2_00A1_00A0, "read_lat2");
  endtask

  task automatic test_wide_read();
    logic [255:0] rdin, wdata;
    for (int k = 0; k < 8; k++) begin
      rdin[k*32 +: 32]  = $urandom;
      wdata[k*32 +: 32] = $urandom;
    end
    sel = 1; #1;
    run_burst(1'b1, $urandom, wdata, rdin, "wide_read");
  endtask

  task automatic test_write_after_read();
    logic [255:0] rdin;
    rdin = '0;
    for (int k = 0; k < 4; k++) rdin[k*16 +: 16] = 16'($urandom);
    sel = 0; #1;
    run_burst(1'b1, $urandom, '0, rdin, "war_read");
    run_burst(1'b0, $urandom, {8{$urandom}}, '0, "war_write");
  endtask

  task automatic test_back_to_back();
    int accepts, pulses, period;
    int acceptAt [3];
    int rspAt [3];
    logic oeHist [50];
    logic accepted;
`ifdef PBM_TURNAROUND_EN
    period = 8;
`else
    period = 7;
`endif
    accepts = 0; pulses = 0;
    for (int k = 0; k < 3; k++) begin acceptAt[k] = -100; rspAt[k] = -100; end
    sel = 0; #1;
    reqValid = 1'b1; reqRw = 1'b0; reqAddr = $urandom; reqWdata = {8{$urandom}};
    for (int c = 0; c < 50; c++) begin
      oeHist[c] = obsOe;
      if (obsRsp) begin
        if (pulses < 3) rspAt[pulses] = c;
        pulses++;
      end
      accepted = obsReady && reqValid;
      if (accepted) begin
        if (accepts < 3) acceptAt[accepts] = c;
        accepts++;
      end
      @(posedge clk); #1;
      if (accepted) begin
        reqAddr = $urandom; reqWdata = {8{$urandom}};
        if (accepts >= 3) reqValid = 1'b0;
      end
    end
    reqValid = 1'b0;
    vectors++;
    if (accepts != 3 || pulses != 3) begin
      miscompares++;
      $display("[TB] FAIL b2b counts: observed %0d accepts %0d pulses expected 3 3", accepts, pulses);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (acceptAt[k] != k * period || rspAt[k] != k * period + 6) begin
        miscompares++;
        $display("[TB] FAIL b2b timing %0d: observed accept %0d rsp %0d expected %0d %0d",
                 k, acceptAt[k], rspAt[k], k * period, k * period + 6);
      end
    end
    for (int k = 1; k < 3; k++) begin
      vectors++;
      if (acceptAt[k] < 1 || oeHist[acceptAt[k]] !== 1'b0 || oeHist[acceptAt[k] - 1] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b gap %0d: bus driven between bursts, expected undriven", k);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] rdin;
    rdin = '0;
    for (int k = 0; k < 4; k++) rdin[k*16 +: 16] = 16'($urandom) | 16'h0001;
    sel = 0; #1;
    run_burst(1'b1, $urandom, '0, rdin, "pre_reset_read");
    reqValid = 1'b1; reqRw = 1'b0; reqAddr = $urandom; reqWdata = {8{$urandom}};
    @(posedge clk); #1;
    reqValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obsOe !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_reset beat1: observed oe %b expected 1", obsOe);
    end
    resetH = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({obsReady, obsRsp, obsOe, obsAv} !== 4'b1000 || obsRdata !== 256'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset abort: observed ctl %b rdata %h expected 1000 0",
               {obsReady, obsRsp, obsOe, obsAv}, obsRdata);
    end
    resetH = 1'b0;
    for (int s = 0; s < 3; s++) lastRdata[s] = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (obsRsp !== 1'b0 || obsOe !== 1'b0 || obsReady !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL mid_reset quiet %0d: observed rsp %b oe %b ready %b expected 0 0 1",
                 c, obsRsp, obsOe, obsReady);
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] rdin, wdata;
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < 8; k++) begin
        rdin[k*32 +: 32]  = $urandom;
        wdata[k*32 +: 32] = $urandom;
      end
      sel = $urandom_range(0, 2); #1;
      run_burst(1'($urandom), $urandom, wdata, rdin, "random");
    end
  endtask

  // Watchdog so a stuck run still terminates with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_defaults();
    test_read_lat2();
    test_wide_read();
    test_write_after_read();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
